cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit_pkg.sv | 31 +++
 rtl/cond_unit_check.sv | 48 ++++
 rtl/cond_unit.sv | 90 +++++++++
 tb/tb_cond_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit: condition-code encodings,
// flag bit positions inside {N,Z,C,V} and FlagW bit positions.
// Optional feature macro: COND_UNDEF_TRAP_EN (Cond=1111 traps as undefined).
package cond_unit_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam int unsigned FLAGW_NZ = 1;
   localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_check.sv
// Combinational condition evaluator: Cond against the architectural flags.
// Optional feature macro: COND_UNDEF_TRAP_EN (Cond=1111 evaluates false).
module cond_check
   import cond_unit_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // Condition map decode
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = ~z & (n == v);
         COND_LE: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         COND_NV: begin
`ifdef COND_UNDEF_TRAP_EN
            CondEx = 1'b0;
`else
            CondEx = 1'b1;
`endif
         end
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: holds the {N,Z,C,V} flag register and the condition-gated
// M-stage control registers. Flush clears the M stage and wins over Stall;
// Stall holds everything. Reset is asynchronous, active-low.
// Optional feature macro: COND_UNDEF_TRAP_EN (registered UndefM trap on Cond=1111).
module cond_unit
   import cond_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       Stall,
   input  logic       Flush,
   output logic       PCSrcM,
   output logic       RegWriteM,
   output logic       MemWriteM,
   output logic [3:0] Flags,
   output logic       CondExE,
   output logic       UndefM
);

   logic [3:0] flags_q;
   logic       adv;
   logic       we_nz;
   logic       we_cv;

   assign Flags = flags_q;
   assign adv   = ~Stall & ~Flush;
   assign we_nz = FlagW[FLAGW_NZ] & CondExE & adv;
   assign we_cv = FlagW[FLAGW_CV] & CondExE & adv;

   cond_check u_check (
      .Cond   (Cond),
      .Flags  (flags_q),
      .CondEx (CondExE)
   );

   // Flag register: each pair written independently when its FlagW bit is set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= '0;
      end else begin
         if (we_nz) begin
            flags_q[FLAG_N] <= ALUFlags[FLAG_N];
            flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (we_cv) begin
            flags_q[FLAG_C] <= ALUFlags[FLAG_C];
            flags_q[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   // M-stage controls: flush clears, stall holds, otherwise gated by CondExE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (Flush) begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (!Stall) begin
         PCSrcM    <= PCS  & CondExE;
         RegWriteM <= RegW & CondExE;
         MemWriteM <= MemW & CondExE;
      end
   end

`ifdef COND_UNDEF_TRAP_EN
   // Undefined-condition trap follows the same flush/stall rules as M controls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         UndefM <= 1'b0;
      end else if (Flush) begin
         UndefM <= 1'b0;
      end else if (!Stall) begin
         UndefM <= (Cond == COND_NV);
      end
   end
`else
   assign UndefM = 1'b0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: the driver pushes hand-computed expectations
// per vector; the monitor pops them, checks CondExE mid-cycle and the
// registered outputs just after the following edge.
// Optional feature macro: COND_UNDEF_TRAP_EN (expectations follow the build).
module tb_cond_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, Stall, Flush;
   logic       PCSrcM, RegWriteM, MemWriteM, CondExE, UndefM;
   logic [3:0] Flags;

   int checks = 0;
   int fails  = 0;
   int issued = 0;
   int done   = 0;

   typedef struct {
      int         id;
      logic       cx;
      logic [3:0] fl;
      logic [3:0] m;   // {pc, rw, mw, ud}
   } exp_t;

   exp_t sb[$];

`ifdef COND_UNDEF_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   cond_unit dut (
      .clk       (clk),
      .reset     (reset),
      .Cond      (Cond),
      .ALUFlags  (ALUFlags),
      .FlagW     (FlagW),
      .PCS       (PCS),
      .RegW      (RegW),
      .MemW      (MemW),
      .Stall     (Stall),
      .Flush     (Flush),
      .PCSrcM    (PCSrcM),
      .RegWriteM (RegWriteM),
      .MemWriteM (MemWriteM),
      .Flags     (Flags),
      .CondExE   (CondExE),
      .UndefM    (UndefM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp);
      end
   endtask

   // Apply one vector just after an edge and queue its expected response
   task automatic issue(input int id, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic [2:0] ctl, input logic [1:0] sf,
                        input logic cx, input logic [3:0] fl, input logic [3:0] m);
      exp_t e;
      @(posedge clk);
      #2;
      Cond = c; ALUFlags = alu; FlagW = fw;
      {PCS, RegW, MemW} = ctl;
      {Stall, Flush} = sf;
      e.id = id; e.cx = cx; e.fl = fl; e.m = m;
      sb.push_back(e);
      issued++;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && done < issued; i++) @(posedge clk);
      if (done < issued) chk("drain_timeout", done, 4'(done), 4'(issued));
   endtask

   // Monitor: CondExE at the falling edge, registered state after the next edge
   initial begin
      exp_t r;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("condexe", r.id, {3'b000, CondExE}, {3'b000, r.cx});
            @(posedge clk);
            #1;
            chk("flags", r.id, Flags, r.fl);
            chk("m_outs", r.id, {PCSrcM, RegWriteM, MemWriteM, UndefM}, r.m);
            done++;
         end
      end
   end

   initial begin
      logic [3:0] fl22;
      logic [3:0] m22;
      fl22 = TRAP ? 4'b0110 : 4'b1001;
      m22  = TRAP ? 4'b0001 : 4'b0010;

      reset = 1'b0;
      Cond = 4'b0000; ALUFlags = '0; FlagW = '0;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Stall = 1'b0; Flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flags", -1, Flags, 4'b0000);
      chk("rst_m", -1, {PCSrcM, RegWriteM, MemWriteM, UndefM}, 4'b0000);
      chk("rst_condexe_eq", -1, {3'b000, CondExE}, 4'b0000);
      @(negedge clk);
      reset = 1'b1;

      //     id cond     alu      fw     ctl     sf     cx    flags    {pc,rw,mw,ud}
      issue( 0, 4'b0000, 4'b1111, 2'b11, 3'b111, 2'b00, 1'b0, 4'b0000, 4'b0000);
      issue( 1, 4'b1110, 4'b0100, 2'b11, 3'b000, 2'b00, 1'b1, 4'b0100, 4'b0000);
      issue( 2, 4'b0000, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b1, 4'b0100, 4'b0100);
      issue( 3, 4'b0001, 4'b0000, 2'b00, 3'b110, 2'b00, 1'b0, 4'b0100, 4'b0000);
      issue( 4, 4'b1110, 4'b1000, 2'b11, 3'b000, 2'b00, 1'b1, 4'b1000, 4'b0000);
      issue( 5, 4'b1010, 4'b0000, 2'b11, 3'b010, 2'b00, 1'b0, 4'b1000, 4'b0000);
      issue( 6, 4'b1011, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b1, 4'b1000, 4'b0100);
      issue( 7, 4'b1110, 4'b0000, 2'b11, 3'b000, 2'b00, 1'b1, 4'b0000, 4'b0000);
      issue( 8, 4'b1110, 4'b0111, 2'b10, 3'b001, 2'b00, 1'b1, 4'b0100, 4'b0010);
      issue( 9, 4'b1110, 4'b1011, 2'b10, 3'b010, 2'b10, 1'b1, 4'b0100, 4'b0010);
      issue(10, 4'b1110, 4'b1111, 2'b11, 3'b100, 2'b11, 1'b1, 4'b0100, 4'b0000);
      issue(11, 4'b1000, 4'b0000, 2'b00, 3'b100, 2'b00, 1'b0, 4'b0100, 4'b0000);
      issue(12, 4'b1110, 4'b1010, 2'b01, 3'b100, 2'b00, 1'b1, 4'b0110, 4'b1000);
      issue(13, 4'b1001, 4'b0000, 2'b00, 3'b001, 2'b00, 1'b1, 4'b0110, 4'b0010);
      issue(14, 4'b1100, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b0, 4'b0110, 4'b0000);
      issue(15, 4'b1101, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b1, 4'b0110, 4'b0100);
      issue(16, 4'b0010, 4'b0000, 2'b00, 3'b100, 2'b00, 1'b1, 4'b0110, 4'b1000);
      issue(17, 4'b0011, 4'b0000, 2'b00, 3'b100, 2'b00, 1'b0, 4'b0110, 4'b0000);
      issue(18, 4'b0100, 4'b0000, 2'b00, 3'b001, 2'b00, 1'b0, 4'b0110, 4'b0000);
      issue(19, 4'b0101, 4'b0000, 2'b00, 3'b001, 2'b00, 1'b1, 4'b0110, 4'b0010);
      issue(20, 4'b0110, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b0, 4'b0110, 4'b0000);
      issue(21, 4'b0111, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b1, 4'b0110, 4'b0100);
      issue(22, 4'b1111, 4'b1001, 2'b11, 3'b001, 2'b00, !TRAP, fl22,    m22);
      issue(23, 4'b1110, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b1, fl22,    4'b0100);
      issue(24, 4'b1111, 4'b0000, 2'b00, 3'b000, 2'b10, !TRAP, fl22,    4'b0100);
      issue(25, 4'b1111, 4'b0000, 2'b00, 3'b000, 2'b11, !TRAP, fl22,    4'b0000);
      drain();

      // Asynchronous reset asserted mid-cycle while stalled
      @(posedge clk);
      #2;
      Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1;
      Stall = 1'b1; Flush = 1'b0;
      reset = 1'b0;
      #1;
      chk("async_rst_flags", -2, Flags, 4'b0000);
      chk("async_rst_m", -2, {PCSrcM, RegWriteM, MemWriteM, UndefM}, 4'b0000);
      @(posedge clk);
      #2;
      reset = 1'b1;

      issue(26, 4'b1110, 4'b0011, 2'b11, 3'b010, 2'b00, 1'b1, 4'b0011, 4'b0100);
      issue(27, 4'b1010, 4'b0000, 2'b00, 3'b010, 2'b00, 1'b0, 4'b0011, 4'b0000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
